lia_demod_channel: RTL and testbench



---
 rtl/lia_pkg.sv | 52 +++++
 rtl/lia_sincos_lut.sv | 31 +++
 rtl/lia_demod_channel.sv | 123 ++++++++++++
 tb/tb_lia_demod_channel.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lia_pkg.sv
// Shared widths and constants for the lock-in demodulation channel, plus the
// integer sine generator used to build the reference table at elaboration.
package lia_pkg;

  localparam int ADC_W      = 14;
  localparam int PHASE_W    = 20;
  localparam int LUT_AW     = 10;
  localparam int SIN_W      = 16;
  localparam int OUT_W      = 16;
  localparam int IIR_FRAC   = 16;
  localparam int K_MAX      = 15;
  localparam int COS_OFFSET = 256;

  localparam longint PI_Q28 = 64'sd843314857;

  function automatic logic [3:0] clamp_k(input logic [4:0] k);
    return (k > 5'(K_MAX)) ? 4'(K_MAX) : k[3:0];
  endfunction

  // Taylor series to x^15; x is radians in Q28, result in Q28.
  function automatic longint sin_fix(input longint x);
    longint x2;
    longint term;
    longint sum;
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // round((2^(dw-1)-1) * sin(2*pi*idx / 2^aw)), same values as lia_sin.mif.
  function automatic longint sin_entry(input int idx, input int aw, input int dw);
    int     qn;
    int     q;
    longint x;
    longint v;
    longint amp;
    qn = 1 << (aw - 2);
    q  = idx & (qn - 1);
    if ((idx & qn) != 0) q = qn - q;
    x   = (longint'(q) * PI_Q28) / longint'(2 * qn);
    amp = (longint'(1) << (dw - 1)) - 1;
    v   = (sin_fix(x) * amp + (longint'(1) << 27)) >>> 28;
    if ((idx & (2 * qn)) != 0) v = -v;
    return v;
  endfunction

endpackage

// File: rtl/lia_sincos_lut.sv
// Dual-read sine ROM: sin at addr and cos at addr + quarter turn, both with
// one registered cycle of latency.
module lia_sincos_lut
  import lia_pkg::*;
#(
  parameter int AW = LUT_AW,
  parameter int DW = SIN_W
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr,
  output logic signed [DW-1:0] sin_q,
  output logic signed [DW-1:0] cos_q
);

  logic signed [DW-1:0] rom [2**AW];
  logic [AW-1:0]        cos_addr;

  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    localparam longint VL = sin_entry(i, AW, DW);
    localparam logic signed [DW-1:0] V = VL[DW-1:0];
    assign rom[i] = V;
  end

  assign cos_addr = addr + AW'(COS_OFFSET);

  always_ff @(posedge clk) begin
    sin_q <= rom[addr];
    cos_q <= rom[cos_addr];
  end

endmodule

// File: rtl/lia_demod_channel.sv
// One lock-in channel: NCO reference, I/Q mixing, first-order IIR low-pass
// and decimated, coherent X/Y output registers.
module lia_demod_channel
  import lia_pkg::*;
#(
  parameter int DEC_LOG2 = 8
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic                      sample_valid,
  input  logic signed [ADC_W-1:0]   sample_data,
  input  logic [PHASE_W-1:0]        phase_incr,
  input  logic [PHASE_W-1:0]        phase_offs,
  input  logic [4:0]                tc_shift,
  input  logic                      sync_clr,
  output logic signed [OUT_W-1:0]   x_out,
  output logic signed [OUT_W-1:0]   y_out,
  output logic                      out_valid
);

  // sample_valid is a push-only strobe: every cycle it is high one sample is
  // accepted, there is no backpressure, and each stage's v flag travels with
  // its data so bubbles flow through unchanged.

  localparam int PROD_W    = ADC_W + SIN_W;
  localparam int ACC_W     = PROD_W + IIR_FRAC + 1;
  localparam int OUT_SHIFT = IIR_FRAC + SIN_W - 2;
  localparam logic [DEC_LOG2:0] DEC_LAST = (DEC_LOG2 + 1)'((1 << DEC_LOG2) - 1);

  logic [PHASE_W-1:0]        phase_acc;
  logic [LUT_AW-1:0]         lut_addr;
  logic                      v0, v1, v2, v3;
  logic signed [ADC_W-1:0]   d0, d1;
  logic signed [SIN_W-1:0]   sin_q, cos_q;
  logic signed [PROD_W-1:0]  px, py;
  logic signed [ACC_W-1:0]   sx, sy;
  logic [DEC_LOG2:0]         dec_cnt;
  logic [3:0]                k_eff;

  assign k_eff = clamp_k(tc_shift);

  // s + ((p<<16 - s) >>> k); the arithmetic shift floors toward -inf.
  function automatic logic signed [ACC_W-1:0] iir_step(
    input logic signed [ACC_W-1:0]  s,
    input logic signed [PROD_W-1:0] p,
    input logic [3:0]               k
  );
    logic signed [ACC_W-1:0] target;
    logic signed [ACC_W-1:0] diff;
    target = ACC_W'(p) <<< IIR_FRAC;
    diff   = target - s;
    return s + (diff >>> k);
  endfunction

  lia_sincos_lut #(
    .AW(LUT_AW),
    .DW(SIN_W)
  ) u_lut (
    .clk   (clk_clk),
    .addr  (lut_addr),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  // Data path registers carry no reset; they are only consumed under a valid.
  always_ff @(posedge clk_clk) begin
    if (sample_valid) begin
      lut_addr <= LUT_AW'((phase_acc + phase_offs) >> (PHASE_W - LUT_AW));
      d0       <= sample_data;
    end
    d1 <= d0;
    px <= PROD_W'(d1) * PROD_W'(sin_q);
    py <= PROD_W'(d1) * PROD_W'(cos_q);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      phase_acc <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      sx        <= '0;
      sy        <= '0;
      dec_cnt   <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else if (sync_clr) begin
      phase_acc <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      sx        <= '0;
      sy        <= '0;
      dec_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      v0 <= sample_valid;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (sample_valid) phase_acc <= phase_acc + phase_incr;
      if (v2) begin
        sx <= iir_step(sx, px, k_eff);
        sy <= iir_step(sy, py, k_eff);
      end
      out_valid <= 1'b0;
      if (v3) begin
        if (dec_cnt == DEC_LAST) begin
          dec_cnt   <= '0;
          x_out     <= OUT_W'(sx >>> OUT_SHIFT);
          y_out     <= OUT_W'(sy >>> OUT_SHIFT);
          out_valid <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt + (DEC_LOG2 + 1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lia_demod_channel.sv
// Directed bench for lia_demod_channel: one instance without decimation and
// one decimating by 4, driven from the same stimulus.
module tb_lia_demod_channel;
  import lia_pkg::*;

  logic clk_clk = 1'b0;
  logic reset_reset;
  logic sample_valid;
  logic signed [ADC_W-1:0] sample_data;
  logic [PHASE_W-1:0] phase_incr;
  logic [PHASE_W-1:0] phase_offs;
  logic [4:0] tc_shift;
  logic sync_clr;
  logic signed [OUT_W-1:0] x0, y0, x2, y2;
  logic ov0, ov2;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  localparam longint P1000 = 64'sd32767000;

  lia_demod_channel #(.DEC_LOG2(0)) dut0 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .phase_incr(phase_incr), .phase_offs(phase_offs),
    .tc_shift(tc_shift), .sync_clr(sync_clr),
    .x_out(x0), .y_out(y0), .out_valid(ov0)
  );

  lia_demod_channel #(.DEC_LOG2(2)) dut2 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .phase_incr(phase_incr), .phase_offs(phase_offs),
    .tc_shift(tc_shift), .sync_clr(sync_clr),
    .x_out(x2), .y_out(y2), .out_valid(ov2)
  );

  // clock / reset
  always #5 clk_clk = ~clk_clk;

  // driver tasks
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input bit use2, input int max_cyc, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      step();
      n++;
      seen = use2 ? ov2 : ov0;
    end
  endtask

  task automatic clear_step();
    sync_clr     = 1'b1;
    sample_valid = 1'b0;
    step();
    sync_clr = 1'b0;
  endtask

  task automatic one_sample(input int v);
    sample_data  = ADC_W'(v);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  function automatic longint iir_model(input longint s, input longint p, input int k);
    return s + (((p <<< 16) - s) >>> k);
  endfunction

  // scoreboard state for the decimating instance
  int pulses2;
  logic signed [OUT_W-1:0] held_x, held_y;

  task automatic mon2();
    logic signed [OUT_W-1:0] e;
    if (ov2) begin
      pulses2++;
      if (exp_q.size() == 0) begin
        check("dec_extra_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("dec_x", x2, e);
        check("dec_y", y2, 0);
      end
      held_x = x2;
      held_y = y2;
    end else begin
      check("dec_hold_x", x2, held_x);
      check("dec_hold_y", y2, held_y);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    int  cnt;
    int  prev;
    longint s;
    logic signed [OUT_W-1:0] e;
    int  dvec [12];

    reset_reset  = 1'b1;
    sample_valid = 1'b1;
    sample_data  = ADC_W'(1000);
    phase_incr   = '0;
    phase_offs   = 20'h40000;
    tc_shift     = 5'd0;
    sync_clr     = 1'b0;

    // reset state, with samples being offered
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_x", x0, 0);
      check("rst_y", y0, 0);
      check("rst_ov", ov0, 0);
    end
    reset_reset  = 1'b0;
    sample_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(ov0) + int'(ov2);
    end
    check("idle_no_ov", cnt, 0);

    // continuous samples, k=0, sin=32767 cos=0
    sample_data  = ADC_W'(1000);
    sample_valid = 1'b1;
    wait_pulse(1'b0, 10, n, seen);
    check("a_seen", seen, 1);
    check("a_latency", n, 5);
    check("a_x", x0, 1999);
    check("a_y", y0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_ov_cont", ov0, 1);
      check("a_x_cont", x0, 1999);
    end
    clear_step();
    check("a_clr_ov", ov0, 0);
    check("a_clr_hold_x", x0, 1999);

    // tc_shift above 15 behaves as 15
    tc_shift = 5'd20;
    one_sample(1000);
    wait_pulse(1'b0, 10, n, seen);
    check("k20_seen", seen, 1);
    check("k20_x", x0, 0);
    clear_step();

    // k=4: first output 124, then monotonic approach to 1999
    tc_shift = 5'd4;
    one_sample(1000);
    wait_pulse(1'b0, 10, n, seen);
    check("k4_seen", seen, 1);
    check("k4_lat", n, 4);
    check("k4_first_x", x0, 124);
    check("k4_first_y", y0, 0);
    prev = 124;
    sample_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ov0) begin
        check("k4_mono", (int'(x0) >= prev && int'(x0) <= 1999) ? 1 : 0, 1);
        prev = int'(x0);
      end
    end
    check("k4_settled_x", x0, 1999);
    clear_step();

    // half-turn phase step: index 0/512, y alternates
    phase_incr = 20'h80000;
    phase_offs = 20'h00000;
    tc_shift   = 5'd0;
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 16'sd1999 : -16'sd2000);
    for (int c = 0; c < 16; c++) begin
      sample_valid = (c < 8);
      step();
      if (ov0) begin
        if (exp_q.size() == 0) begin
          check("alt_extra_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("alt_y", y0, e);
          check("alt_x", x0, 0);
        end
      end
    end
    check("alt_left", exp_q.size(), 0);
    exp_q.delete();

    // decimate-by-4 with random gaps
    phase_incr = '0;
    phase_offs = 20'h40000;
    clear_step();
    dvec = '{1000, -1000, 2500, 8191, -8192, 37, -1, 4000, 123, -4567, 7000, -3};
    pulses2 = 0;
    held_x  = x2;
    held_y  = y2;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) exp_q.push_back(OUT_W'((longint'(dvec[i]) * 32767) >>> 14));
      sample_data  = ADC_W'(dvec[i]);
      sample_valid = 1'b1;
      step();
      mon2();
      sample_valid = 1'b0;
      cnt = $urandom_range(1, 3);
      for (int g = 0; g < cnt; g++) begin
        step();
        mon2();
      end
    end
    for (int i = 0; i < 8; i++) begin
      step();
      mon2();
    end
    check("dec_pulses", pulses2, 3);
    check("dec_left", exp_q.size(), 0);
    exp_q.delete();

    // sync_clr mid-stream with sample_valid high
    clear_step();
    phase_incr  = 20'h80000;
    phase_offs  = 20'h40000;
    tc_shift    = 5'd4;
    sample_data = ADC_W'(1000);
    s = 0;
    s = iir_model(s,  P1000, 4);
    s = iir_model(s, -P1000, 4);
    s = iir_model(s,  P1000, 4);
    sample_valid = 1'b1;
    for (int c = 0; c < 7; c++) step();
    check("e_pre_ov", ov0, 1);
    check("e_pre_x", x0, longint'(OUT_W'(s >>> 30)) >= 32768 ?
          longint'(OUT_W'(s >>> 30)) - 65536 : longint'(OUT_W'(s >>> 30)));
    sync_clr = 1'b1;
    step();
    sync_clr     = 1'b0;
    sample_valid = 1'b0;
    check("e_clr_ov", ov0, 0);
    check("e_clr_hold_x", x0, s >>> 30);
    check("e_clr_hold_y", y0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("e_quiet_ov", ov0, 0);
      check("e_quiet_hold_x", x0, s >>> 30);
    end
    one_sample(1000);
    wait_pulse(1'b0, 10, n, seen);
    check("e_seen", seen, 1);
    check("e_restart_x", x0, 124);
    check("e_restart_y", y0, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
